// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master: FSM state encoding and default rates.
//   IDLE..DONE  : transfer sequencing states
//   SPI_CLK_DIV_DEFAULT : clk cycles per sclk half-period (24 MHz clk -> 2.4 MHz sclk)
//   SPI_DATA_W_DEFAULT  : bits per transfer
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SETUP    = 3'd1,
    TRANSFER = 3'd2,
    HOLD     = 3'd3,
    DONE     = 3'd4
  } spi_state_e;

  localparam int unsigned SPI_CLK_DIV_DEFAULT = 5;
  localparam int unsigned SPI_DATA_W_DEFAULT  = 16;

endpackage

// File: rtl/spi_sclk_gen.sv
// Half-period tick counter and registered sclk level for the SPI master.
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   run        : tick counter enabled (SETUP/TRANSFER/HOLD)
//   toggle_en  : sclk toggles on each tick (TRANSFER only); otherwise sclk = CPOL
//   tick_c     : last clk cycle of a CLK_DIV half-period (combinational)
//   lead_c     : tick that moves sclk away from idle (combinational)
//   trail_c    : tick that returns sclk to idle (combinational)
//   sclk       : registered serial clock level
module spi_sclk_gen
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = SPI_CLK_DIV_DEFAULT,
  parameter bit          CPOL    = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic toggle_en,
  output logic tick_c,
  output logic lead_c,
  output logic trail_c,
  output logic sclk
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CNT_W-1:0] cnt;

  // Edge strobes are qualified by the current sclk level so they fire on the
  // same clk edge that updates sclk.
  assign tick_c  = run && (cnt == CNT_W'(CLK_DIV - 1));
  assign lead_c  = tick_c && toggle_en && (sclk == CPOL);
  assign trail_c = tick_c && toggle_en && (sclk != CPOL);

  // Tick counter restarts each half-period; held at zero while idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      sclk <= CPOL;
    end else begin
      if (!run || tick_c) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
      if (!toggle_en) begin
        sclk <= CPOL;
      end else if (tick_c) begin
        sclk <= ~sclk;
      end
    end
  end

endmodule

// File: rtl/spi_master.sv
// SPI master: one DATA_W-bit full-duplex transfer per accepted start request.
// Ports:
//   clk, reset     : system clock, synchronous active-high reset
//   start_transfer : request, accepted only in IDLE
//   data_to_tx     : word to send, captured on acceptance
//   data_rx        : last received word, updated on entry to DONE
//   transfer_done  : one-cycle completion pulse (DONE state)
//   transfer_busy  : high from SETUP through HOLD
//   sclk, mosi, cs : serial clock, master data out, chip select (all registered)
//   miso           : slave data in
module spi_master
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W    = SPI_DATA_W_DEFAULT,
  parameter int unsigned CLK_DIV   = SPI_CLK_DIV_DEFAULT,
  parameter bit          CPOL      = 1'b0,
  parameter bit          CPHA      = 1'b0,
  parameter bit          LSB_FIRST = 1'b1,
  parameter bit          CS_ACTIVE = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_transfer,
  input  logic [DATA_W-1:0] data_to_tx,
  output logic [DATA_W-1:0] data_rx,
  output logic              transfer_done,
  output logic              transfer_busy,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic              cs
);

  localparam int unsigned BIT_W = $clog2(DATA_W);

  spi_state_e        state;
  spi_state_e        state_nxt;
  logic [DATA_W-1:0] tx_sr;
  logic [DATA_W-1:0] rx_sr;
  logic [BIT_W-1:0]  bit_cnt;

  logic run;
  logic toggle_en;
  logic tick_c;
  logic lead_c;
  logic trail_c;
  logic accept;
  logic shift_edge;
  logic sample_edge;
  logic last_bit;
  logic active_nxt;

  // Next bit to drive, given the configured bit order.
  function automatic logic first_bit(input logic [DATA_W-1:0] w);
    return LSB_FIRST ? w[0] : w[DATA_W-1];
  endfunction

  // Drop the bit just driven.
  function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w);
    return LSB_FIRST ? (w >> 1) : (w << 1);
  endfunction

  // Insert a received bit so the first bit lands at the configured end.
  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] w, input logic b);
    return LSB_FIRST ? {b, w[DATA_W-1:1]} : {w[DATA_W-2:0], b};
  endfunction

  spi_sclk_gen #(
    .CLK_DIV (CLK_DIV),
    .CPOL    (CPOL)
  ) u_sclk_gen (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .toggle_en (toggle_en),
    .tick_c    (tick_c),
    .lead_c    (lead_c),
    .trail_c   (trail_c),
    .sclk      (sclk)
  );

  assign run         = (state == SETUP) || (state == TRANSFER) || (state == HOLD);
  assign toggle_en   = (state == TRANSFER);
  assign accept      = (state == IDLE) && start_transfer;
  // CPHA=0 samples on the leading edge and shifts on the trailing edge; CPHA=1 swaps them.
  assign shift_edge  = CPHA ? lead_c : trail_c;
  assign sample_edge = CPHA ? trail_c : lead_c;
  assign last_bit    = (bit_cnt == BIT_W'(DATA_W - 1));
  assign active_nxt  = (state_nxt == SETUP) || (state_nxt == TRANSFER) || (state_nxt == HOLD);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:     if (start_transfer)      state_nxt = SETUP;
      SETUP:    if (tick_c)              state_nxt = TRANSFER;
      TRANSFER: if (trail_c && last_bit) state_nxt = HOLD;
      HOLD:     if (tick_c)              state_nxt = DONE;
      DONE:                              state_nxt = IDLE;
      default:                           state_nxt = IDLE;
    endcase
  end

  // Shift registers, bit counter and registered outputs (decoded from next state).
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_sr         <= '0;
      rx_sr         <= '0;
      bit_cnt       <= '0;
      data_rx       <= '0;
      transfer_done <= 1'b0;
      transfer_busy <= 1'b0;
      cs            <= ~CS_ACTIVE;
      mosi          <= 1'b0;
    end else begin
      transfer_done <= (state_nxt == DONE);
      transfer_busy <= active_nxt;
      cs            <= active_nxt ? CS_ACTIVE : ~CS_ACTIVE;
      if (accept) begin
        bit_cnt <= '0;
        rx_sr   <= '0;
        // CPHA=0 must present the first bit before the first (sampling) edge.
        if (CPHA) begin
          tx_sr <= data_to_tx;
          mosi  <= 1'b0;
        end else begin
          tx_sr <= shift_out(data_to_tx);
          mosi  <= first_bit(data_to_tx);
        end
      end else begin
        if (shift_edge) begin
          mosi  <= first_bit(tx_sr);
          tx_sr <= shift_out(tx_sr);
        end
        if (sample_edge) begin
          rx_sr <= shift_in(rx_sr, miso);
        end
        // Counts completed bits; saturates at the last bit so it never wraps.
        if (trail_c && !last_bit) begin
          bit_cnt <= bit_cnt + BIT_W'(1);
        end
        if (state_nxt == DONE) begin
          data_rx <= rx_sr;
          mosi    <= 1'b0;
          bit_cnt <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_master.sv
module tb_spi_master;

  localparam int unsigned DONE0 = 1 + (2 * 16 + 2) * 5;
  localparam int unsigned DONE1 = 1 + (2 * 8 + 2) * 2;

  logic clk = 1'b0;
  logic reset;

  logic        start0;
  logic [15:0] data0;
  logic [15:0] rx0;
  logic        done0, busy0, sclk0, mosi0, miso0, cs0;

  logic        start1;
  logic [7:0]  data1;
  logic [7:0]  rx1;
  logic        done1, busy1, sclk1, mosi1, miso1, cs1;

  // Slave models and loopback select
  logic        loop0 = 1'b1;
  logic [15:0] s0_word = '0;
  logic        s0_bit = 1'b0;
  logic        s0_act = 1'b0;
  logic [4:0]  s0_idx = '0;
  logic [7:0]  s1_word = '0;
  logic        s1_bit = 1'b0;
  logic        s1_act = 1'b0;
  logic [3:0]  s1_idx = '0;

  int unsigned rises0 = 0;
  int unsigned rises1 = 0;
  logic [15:0] mosi_acc0 = '0;
  logic [7:0]  mosi_acc1 = '0;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  logic [15:0] rt0, rs0;
  logic [7:0]  rt1, rs1;
  logic        rl0;
  int unsigned n_extra;

  always #5 clk = ~clk;

  spi_master u_dut0 (
    .clk            (clk),
    .reset          (reset),
    .start_transfer (start0),
    .data_to_tx     (data0),
    .data_rx        (rx0),
    .transfer_done  (done0),
    .transfer_busy  (busy0),
    .sclk           (sclk0),
    .mosi           (mosi0),
    .miso           (miso0),
    .cs             (cs0)
  );

  spi_master #(
    .DATA_W    (8),
    .CLK_DIV   (2),
    .CPOL      (1'b1),
    .CPHA      (1'b1),
    .LSB_FIRST (1'b0),
    .CS_ACTIVE (1'b0)
  ) u_dut1 (
    .clk            (clk),
    .reset          (reset),
    .start_transfer (start1),
    .data_to_tx     (data1),
    .data_rx        (rx1),
    .transfer_done  (done1),
    .transfer_busy  (busy1),
    .sclk           (sclk1),
    .mosi           (mosi1),
    .miso           (miso1),
    .cs             (cs1)
  );

  assign miso0 = loop0 ? mosi0 : s0_bit;
  assign miso1 = s1_bit;

  // Mode-0 LSB-first slave: first bit on cs assertion, next bit after each falling sclk.
  always @(posedge cs0 or negedge cs0 or negedge sclk0) begin
    if (cs0 !== 1'b0) begin
      s0_act = 1'b0;
    end else if (!s0_act) begin
      s0_act = 1'b1;
      s0_idx = 5'd1;
      s0_bit = s0_word[0];
    end else if (s0_idx < 5'd16) begin
      s0_bit = s0_word[s0_idx[3:0]];
      s0_idx = s0_idx + 5'd1;
    end
  end

  // Mode-3 MSB-first slave: drives the next bit on each falling (leading) sclk edge.
  always @(posedge cs1 or negedge cs1 or negedge sclk1) begin
    if (cs1 !== 1'b0) begin
      s1_act = 1'b0;
    end else if (!s1_act) begin
      s1_act = 1'b1;
      s1_idx = 4'd0;
    end else if (s1_idx < 4'd8) begin
      s1_bit = s1_word[3'd7 - s1_idx[2:0]];
      s1_idx = s1_idx + 4'd1;
    end
  end

  // Slave-side view of mosi: both configurations sample on the rising sclk edge.
  always @(posedge sclk0) begin
    rises0    = rises0 + 1;
    mosi_acc0 = {mosi0, mosi_acc0[15:1]};
  end

  always @(posedge sclk1) begin
    rises1    = rises1 + 1;
    mosi_acc1 = {mosi_acc1[6:0], mosi1};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // One default-config transfer; returns in the DONE cycle.
  task automatic xfer0(input string tag, input logic [15:0] tx, input logic lb,
                       input logic [15:0] sw, input logic keep, input logic poke);
    logic [15:0] exp_rx;
    logic [15:0] prev_rx;
    int unsigned r0, done_at, n_done;
    logic        act_ok, held_ok;
    exp_rx = lb ? tx : sw;
    @(negedge clk);
    chk({tag, "_idle"}, 32'({cs0, sclk0, mosi0, busy0}), 32'(4'b1000));
    prev_rx = rx0;
    data0   = tx;
    loop0   = lb;
    s0_word = sw;
    start0  = 1'b1;
    r0      = rises0;
    done_at = 0;
    n_done  = 0;
    act_ok  = 1'b1;
    held_ok = 1'b1;
    for (int k = 1; k <= int'(DONE0); k++) begin
      @(negedge clk);
      if (k == 1) begin
        data0 = ~tx;
        if (!keep) start0 = 1'b0;
      end
      if (poke && (k == 10 || k == 100)) start0 = 1'b1;
      if (poke && (k == 11 || k == 101)) start0 = 1'b0;
      if (k < int'(DONE0)) begin
        if (cs0 !== 1'b0 || busy0 !== 1'b1) act_ok = 1'b0;
        if (rx0 !== prev_rx) held_ok = 1'b0;
      end
      if (done0 === 1'b1) begin
        n_done++;
        if (done_at == 0) done_at = k;
      end
    end
    chk({tag, "_active"},  32'(act_ok), 32'(1));
    chk({tag, "_rx_held"}, 32'(held_ok), 32'(1));
    chk({tag, "_done_at"}, done_at, DONE0);
    chk({tag, "_n_done"},  n_done, 32'd1);
    chk({tag, "_rx"},      32'(rx0), 32'(exp_rx));
    chk({tag, "_rises"},   rises0 - r0, 32'd16);
    chk({tag, "_mosi"},    32'(mosi_acc0), 32'(tx));
    chk({tag, "_done_st"}, 32'({cs0, busy0}), 32'(2'b10));
  endtask

  // One mode-3 MSB-first 8-bit transfer; returns in the DONE cycle.
  task automatic xfer1(input string tag, input logic [7:0] tx, input logic [7:0] sw);
    int unsigned r1, done_at, n_done;
    logic        act_ok;
    @(negedge clk);
    chk({tag, "_idle"}, 32'({cs1, sclk1, mosi1, busy1}), 32'(4'b1100));
    data1   = tx;
    s1_word = sw;
    start1  = 1'b1;
    r1      = rises1;
    done_at = 0;
    n_done  = 0;
    act_ok  = 1'b1;
    for (int k = 1; k <= int'(DONE1); k++) begin
      @(negedge clk);
      if (k == 1) begin
        start1 = 1'b0;
        data1  = ~tx;
      end
      if (k < int'(DONE1) && (cs1 !== 1'b0 || busy1 !== 1'b1)) act_ok = 1'b0;
      if (k <= 2 && sclk1 !== 1'b1) act_ok = 1'b0;
      if (done1 === 1'b1) begin
        n_done++;
        if (done_at == 0) done_at = k;
      end
    end
    chk({tag, "_active"},  32'(act_ok), 32'(1));
    chk({tag, "_done_at"}, done_at, DONE1);
    chk({tag, "_n_done"},  n_done, 32'd1);
    chk({tag, "_rx"},      32'(rx1), 32'(sw));
    chk({tag, "_rises"},   rises1 - r1, 32'd8);
    chk({tag, "_mosi"},    32'(mosi_acc1), 32'(tx));
    chk({tag, "_done_st"}, 32'({cs1, sclk1, busy1}), 32'(3'b110));
  endtask

  initial begin
    reset  = 1'b1;
    start0 = 1'b0;
    start1 = 1'b0;
    data0  = '0;
    data1  = '0;
    repeat (3) @(negedge clk);
    chk("rst0_pins", 32'({cs0, sclk0, mosi0, busy0, done0}), 32'(5'b10000));
    chk("rst0_rx",   32'(rx0), 32'(0));
    chk("rst1_pins", 32'({cs1, sclk1, mosi1, busy1, done1}), 32'(5'b11000));
    chk("rst1_rx",   32'(rx1), 32'(0));
    reset = 1'b0;

    // Default loopback transfer
    xfer0("loop_a5c3", 16'hA5C3, 1'b1, 16'h0000, 1'b0, 1'b0);

    // Mode 3, MSB first, independent slave data
    xfer1("m3_81", 8'h81, 8'h3C);

    // Extra start pulses mid-transfer must be ignored
    xfer0("poke", 16'h1234, 1'b0, 16'hBEEF, 1'b0, 1'b1);
    n_extra = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (busy0 !== 1'b0 || done0 !== 1'b0) n_extra++;
    end
    chk("poke_quiet", n_extra, 32'd0);

    // Back-to-back with start held high
    xfer0("b2b_0001", 16'h0001, 1'b1, 16'h0000, 1'b1, 1'b0);
    xfer0("b2b_8000", 16'h8000, 1'b1, 16'h0000, 1'b0, 1'b0);

    // Reset in the middle of a transfer
    @(negedge clk);
    data0  = 16'h5A5A;
    loop0  = 1'b1;
    start0 = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == 1) start0 = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    chk("abort_pins", 32'({cs0, sclk0, mosi0, busy0, done0}), 32'(5'b10000));
    chk("abort_rx",   32'(rx0), 32'(0));
    reset = 1'b0;
    @(negedge clk);
    // Start coincident with reset while idle
    reset  = 1'b1;
    start0 = 1'b1;
    @(negedge clk);
    reset  = 1'b0;
    start0 = 1'b0;
    @(negedge clk);
    chk("start_in_rst", 32'({cs0, busy0}), 32'(2'b10));
    n_extra = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (done0 !== 1'b0 || busy0 !== 1'b0) n_extra++;
    end
    chk("abort_quiet", n_extra, 32'd0);
    xfer0("post_rst", 16'hC001, 1'b1, 16'h0000, 1'b0, 1'b0);

    // Randomized transfers on both configurations
    for (int i = 0; i < 4; i++) begin
      rt0 = 16'($urandom);
      rs0 = 16'($urandom);
      rl0 = 1'($urandom);
      xfer0("rnd0", rt0, rl0, rs0, 1'b0, 1'b0);
      rt1 = 8'($urandom);
      rs1 = 8'($urandom);
      xfer1("rnd1", rt1, rs1);
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
